mdu_issue_ctrl: RTL and testbench
=================================

Name: mdu_issue_ctrl

Overview:
Initiator side of the E-stage multiply/divide unit interface.
- Drives the MDU's mduOp/start inputs from the E-stage instruction.
- Predicts MDU busy internally and produces the D-stage stall for MDU-using instructions.
- Cross-checks the MDU's busy output against that prediction and flags protocol violations.
- Sits between the E-stage pipeline register and the MDU; stall_d feeds the hazard unit.

Parameters:
- LAT_MUL, 5, cycles busy stays high after a mult/multu start (legal range 1..15).
- LAT_DIV, 10, cycles busy stays high after a div/divu start (legal range 1..15).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- e_valid  in  1  E stage holds a real (non-bubble) instruction this cycle; high for exactly one cycle per instruction.
- e_op  in  4  MDU op of the E-stage instruction (mduOp encoding).
- d_mdu_use  in  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- mdu_busy  in  1  busy output of the MDU.
- mdu_op  out  4  mduOp to the MDU.
- mdu_start  out  1  start to the MDU.
- stall_d  out  1  freeze F/D and insert a bubble into E.
- pend  out  1  predicted MDU busy (state==RUN).
- proto_err  out  1  sticky protocol-violation flag.
- stall_cnt  out  CNT_W  saturating count of cycles with stall_d high.

Behaviour:
Encoding (shared):
- NOPE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
- is_md = op in {MULT, MULTU, DIV, DIVU}.

Combinational outputs:
- mdu_op = e_valid ? e_op : NOPE.
- mdu_start = e_valid & is_md(e_op) & (state==IDLE).
- stall_d = d_mdu_use & (mdu_start | state==RUN).
- pend = (state==RUN).

FSM (cnt is a 4-bit register):
- IDLE: on mdu_start, go to RUN; cnt <= LAT_MUL for mult/multu, LAT_DIV for div/divu.
- RUN, cnt>1: cnt <= cnt-1.
- RUN, cnt==1: go to IDLE, cnt <= 0.
- Resulting pend waveform: high for exactly LAT cycles, starting the cycle after the start edge. This matches the MDU: busy rises on the start edge and falls LAT edges later.

Protocol checks (proto_err sets on the next edge and stays set until reset):
- mdu_busy != pend in any cycle.
- e_valid & is_md(e_op) while state==RUN (start suppressed, op lost).
- e_valid & e_op in {MTHI, MTLO, MFHI, MFLO} while state==RUN, since the MDU ignores mthi/mtlo while counting.
- e_op > 8 with e_valid.

Other rules:
- MFHI/MFLO/MTHI/MTLO in IDLE: passed through on mdu_op; no start; no state change.
- Back-to-back: a D-stage MDU op behind a start stalls from the start cycle through the last RUN cycle (LAT+1 cycles total).
- stall_cnt: increments every cycle stall_d=1; holds at all-ones.
- Reset (async, active-low): state=IDLE, cnt=0, proto_err=0, stall_cnt=0.
  - mdu_start=0 and pend=0 immediately.
  - stall_d then depends only on d_mdu_use & mdu_start, i.e. 0 while reset is asserted.
  - Reset mid-RUN abandons the operation; the MDU must be reset by the same net.

Decomposition:
- Shared package/def header: mduOp encodings, is_md predicate, LAT_MUL/LAT_DIV defaults.
- One natural sub-module, mdu_lat_tracker: the IDLE/RUN FSM plus cnt and pend. The top keeps the decode, stall, checks and perf counter.

Test Plan:
- MULT at cycle 0 (e_valid=1, e_op=1), mdu_busy modelled by the MDU → mdu_start=1 at cycle 0 only; pend=1 for cycles 1–5; proto_err=0.
- DIVU, then MFLO in D from cycle 0 → stall_d=1 for cycles 0–10 (11 cycles); stall_cnt=11; MFLO issues at cycle 11 with no start.
- MTHI in E while IDLE → mdu_op=5, mdu_start=0, pend stays 0.
- Force e_valid=1, e_op=MULT at cycle 2 of a running DIV → mdu_start=0, proto_err=1 from cycle 3 and held.
- Model MDU busy dropping at cycle 4 after a MULT → proto_err=1 at cycle 5.
- Pull reset low at cycle 3 of a DIV → pend=0, cnt=0, stall_cnt=0 immediately. After release, a new MULT starts normally.

Source files
------------

// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared definitions for the E-stage MDU issue controller: mduOp encodings,
// op-class predicates, default latencies and tracker state codes.
package mdu_issue_ctrl_pkg;

    localparam logic [3:0] OP_NOPE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam int LAT_MUL_DEF = 5;
    localparam int LAT_DIV_DEF = 10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Ops that start the MDU and occupy it for a latency window
    function automatic logic is_md(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    // HI/LO moves: no start, but illegal while the MDU is counting
    function automatic logic is_hilo(input logic [3:0] op);
        return (op >= OP_MTHI) && (op <= OP_MFLO);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_lat.sv
// Latency tracker: predicts MDU busy by counting down the op latency.
//
//   state | meaning
//   IDLE  | MDU free, a start may be issued
//   RUN   | MDU counting; pend high, r_cnt cycles remain (including this one)
module mdu_lat_tracker
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int LAT_MUL = LAT_MUL_DEF,
    parameter int LAT_DIV = LAT_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_is_div,
    output logic o_pend
);

    localparam logic [3:0] W_LAT_MUL = 4'(LAT_MUL);
    localparam logic [3:0] W_LAT_DIV = 4'(LAT_DIV);

    logic [0:0] r_state;
    logic [3:0] r_cnt;

    // IDLE/RUN sequencing with a down-counter; leaves RUN when the count hits 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_RUN;
                        r_cnt   <= i_is_div ? W_LAT_DIV : W_LAT_MUL;
                    end
                end
                default: begin
                    if (r_cnt > 4'd1) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
                    end
                end
            endcase
        end
    end

    assign o_pend = (r_state == ST_RUN);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage MDU initiator: issues mduOp/start, stalls D behind a busy MDU,
// cross-checks MDU busy against the local prediction and counts stall cycles.
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int LAT_MUL = LAT_MUL_DEF,
    parameter int LAT_DIV = LAT_DIV_DEF,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_valid,
    input  logic [3:0]       e_op,
    input  logic             d_mdu_use,
    input  logic             mdu_busy,
    output logic [3:0]       mdu_op,
    output logic             mdu_start,
    output logic             stall_d,
    output logic             pend,
    output logic             proto_err,
    output logic [CNT_W-1:0] stall_cnt
);

    logic w_is_md;
    logic w_is_hilo;
    logic w_viol;
    logic r_proto_err;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_is_md   = is_md(e_op);
    assign w_is_hilo = is_hilo(e_op);

    // Start is forced low during reset so the stall it feeds is also quiet
    assign mdu_op    = e_valid ? e_op : OP_NOPE;
    assign mdu_start = reset & e_valid & w_is_md & ~pend;
    assign stall_d   = d_mdu_use & (mdu_start | pend);

    mdu_lat_tracker #(
        .LAT_MUL (LAT_MUL),
        .LAT_DIV (LAT_DIV)
    ) u_lat (
        .clk      (clk),
        .reset    (reset),
        .i_start  (mdu_start),
        .i_is_div (is_div(e_op)),
        .o_pend   (pend)
    );

    assign w_viol = (mdu_busy != pend)
                  | (e_valid & pend & (w_is_md | w_is_hilo))
                  | (e_valid & (e_op > OP_MFLO));

    // Sticky protocol-violation flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_proto_err <= 1'b0;
        end else if (w_viol) begin
            r_proto_err <= 1'b1;
        end
    end

    // Saturating count of stalled D-stage cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (stall_d && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign proto_err = r_proto_err;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl with a behavioural MDU busy model.
module tb_mdu_issue_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          e_valid;
    logic [3:0]    e_op;
    logic          d_mdu_use;
    logic          mdu_busy;
    logic [3:0]    mdu_op;
    logic          mdu_start;
    logic          stall_d;
    logic          pend;
    logic          proto_err;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // MDU model: busy rises on the start edge, falls LAT edges later
    int   m_cnt;
    logic force_en;
    logic force_val;

    always #5 clk = ~clk;

    mdu_issue_ctrl #(
        .LAT_MUL (5),
        .LAT_DIV (10),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .e_valid   (e_valid),
        .e_op      (e_op),
        .d_mdu_use (d_mdu_use),
        .mdu_busy  (mdu_busy),
        .mdu_op    (mdu_op),
        .mdu_start (mdu_start),
        .stall_d   (stall_d),
        .pend      (pend),
        .proto_err (proto_err),
        .stall_cnt (stall_cnt)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                m_cnt <= 0;
        else if (mdu_start)        m_cnt <= (mdu_op == 4'd3 || mdu_op == 4'd4) ? 10 : 5;
        else if (m_cnt > 0)        m_cnt <= m_cnt - 1;
    end

    assign mdu_busy = force_en ? force_val : (m_cnt != 0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        e_valid   = 1'b0;
        e_op      = 4'd0;
        d_mdu_use = 1'b0;
        force_en  = 1'b0;
        force_val = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        #1;
        chk("rst_pend",  32'(pend), 0);
        chk("rst_err",   32'(proto_err), 0);
        chk("rst_cnt",   32'(stall_cnt), 0);
        chk("rst_op",    32'(mdu_op), 0);

        // MULT at cycle 0: start once, pend for cycles 1..5
        e_valid = 1'b1; e_op = 4'd1;
        #1;
        chk("mul_start0", 32'(mdu_start), 1);
        chk("mul_op0",    32'(mdu_op), 1);
        chk("mul_pend0",  32'(pend), 0);
        tick();
        e_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            chk("mul_pend",  32'(pend), 1);
            chk("mul_start", 32'(mdu_start), 0);
            chk("mul_op",    32'(mdu_op), 0);
            tick();
        end
        #1;
        chk("mul_pend6", 32'(pend), 0);
        chk("mul_err",   32'(proto_err), 0);

        // DIVU with MFLO waiting in D: stall cycles 0..10
        do_reset();
        e_valid = 1'b1; e_op = 4'd4; d_mdu_use = 1'b1;
        #1;
        chk("divu_start", 32'(mdu_start), 1);
        chk("divu_stall0", 32'(stall_d), 1);
        tick();
        e_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            #1;
            chk("divu_stall", 32'(stall_d), 1);
            tick();
        end
        #1;
        chk("divu_stall11", 32'(stall_d), 0);
        chk("divu_cnt",     32'(stall_cnt), 11);
        e_valid = 1'b1; e_op = 4'd8; d_mdu_use = 1'b0;
        #1;
        chk("mflo_op",    32'(mdu_op), 8);
        chk("mflo_start", 32'(mdu_start), 0);
        tick();
        e_valid = 1'b0;
        #1;
        chk("mflo_pend", 32'(pend), 0);
        chk("mflo_err",  32'(proto_err), 0);

        // MTHI while idle: passthrough, no start
        e_valid = 1'b1; e_op = 4'd5;
        #1;
        chk("mthi_op",    32'(mdu_op), 5);
        chk("mthi_start", 32'(mdu_start), 0);
        tick();
        e_valid = 1'b0;
        #1;
        chk("mthi_pend", 32'(pend), 0);
        chk("mthi_err",  32'(proto_err), 0);

        // MULT issued during a running DIV: suppressed, sticky error
        do_reset();
        e_valid = 1'b1; e_op = 4'd3;
        tick();
        e_valid = 1'b0;
        tick();
        e_valid = 1'b1; e_op = 4'd1;
        #1;
        chk("lost_start", 32'(mdu_start), 0);
        chk("lost_err2",  32'(proto_err), 0);
        tick();
        e_valid = 1'b0;
        #1;
        chk("lost_err3", 32'(proto_err), 1);
        repeat (12) tick();
        chk("lost_hold", 32'(proto_err), 1);
        chk("lost_idle", 32'(pend), 0);

        // MTLO while running
        do_reset();
        e_valid = 1'b1; e_op = 4'd1;
        tick();
        e_op = 4'd6;
        #1;
        chk("mtlo_err1", 32'(proto_err), 0);
        tick();
        e_valid = 1'b0;
        #1;
        chk("mtlo_err2", 32'(proto_err), 1);
        repeat (5) tick();

        // Undefined op 9
        do_reset();
        e_valid = 1'b1; e_op = 4'd9;
        #1;
        chk("op9_start", 32'(mdu_start), 0);
        chk("op9_err0",  32'(proto_err), 0);
        tick();
        e_valid = 1'b0;
        #1;
        chk("op9_err1", 32'(proto_err), 1);
        chk("op9_pend", 32'(pend), 0);

        // MDU busy drops early at cycle 4 of a MULT
        do_reset();
        e_valid = 1'b1; e_op = 4'd1;
        tick();
        e_valid = 1'b0;
        tick();
        tick();
        #1;
        chk("early_err3", 32'(proto_err), 0);
        tick();
        force_en = 1'b1; force_val = 1'b0;
        #1;
        chk("early_err4", 32'(proto_err), 0);
        tick();
        force_en = 1'b0;
        #1;
        chk("early_err5", 32'(proto_err), 1);
        repeat (3) tick();

        // Reset mid-DIV, then a fresh MULT
        do_reset();
        e_valid = 1'b1; e_op = 4'd3; d_mdu_use = 1'b1;
        tick();
        e_valid = 1'b0;
        tick();
        tick();
        #1;
        chk("mid_cnt3",  32'(stall_cnt), 3);
        chk("mid_pend3", 32'(pend), 1);
        rst_n = 1'b0;
        e_valid = 1'b1; e_op = 4'd1;
        #1;
        chk("mid_rst_pend",  32'(pend), 0);
        chk("mid_rst_start", 32'(mdu_start), 0);
        chk("mid_rst_stall", 32'(stall_d), 0);
        chk("mid_rst_cnt",   32'(stall_cnt), 0);
        tick();
        chk("mid_rst_pend2", 32'(pend), 0);
        rst_n = 1'b1; d_mdu_use = 1'b0;
        #1;
        chk("post_start", 32'(mdu_start), 1);
        tick();
        e_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            chk("post_pend", 32'(pend), 1);
            tick();
        end
        #1;
        chk("post_pend6", 32'(pend), 0);
        chk("post_err",   32'(proto_err), 0);

        // Two back-to-back DIVs with D stalled: 22 stalls saturate at 15
        do_reset();
        e_valid = 1'b1; e_op = 4'd3; d_mdu_use = 1'b1;
        tick();
        e_valid = 1'b0;
        repeat (10) tick();
        e_valid = 1'b1; e_op = 4'd3;
        #1;
        chk("b2b_start", 32'(mdu_start), 1);
        chk("b2b_stall", 32'(stall_d), 1);
        tick();
        e_valid = 1'b0;
        repeat (10) tick();
        #1;
        chk("sat_cnt", 32'(stall_cnt), 15);
        chk("sat_err", 32'(proto_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
